// File: rtl/serial_subtractor4_if.sv
// Start/done handshake and result bus for the bit-serial subtractor.
interface serial_subtractor4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // Sequencer side: issues operands, observes status and result.
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop replaces WIDTH parallel cells.
// Result, borrow and overflow are registered and held until the next completion.
module serial_subtractor4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3   // 2**CW must exceed WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_subtractor4_if.slave bus
);

    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q, b_msb_q;
    logic             busy_q, done_q, bout_q, ovf_q;
    logic [WIDTH-1:0] diff_q;

    logic             x, y, d, brw_nxt;
    logic [WIDTH-1:0] r_nxt;

    // Full-subtractor cell on the current LSBs, and the result shifted in at the MSB.
    always_comb begin
        x       = a_sh_q[0];
        y       = b_sh_q[0];
        d       = x ^ y ^ brw_q;
        brw_nxt = (~x & y) | (~(x ^ y) & brw_q);
        r_nxt   = {d, r_sh_q[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        brw_q   <= bus.bin;
                        cnt_q   <= '0;
                        r_sh_q  <= '0;
                        a_msb_q <= bus.a[WIDTH-1];
                        b_msb_q <= bus.b[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    brw_q  <= brw_nxt;
                    r_sh_q <= r_nxt;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        diff_q  <= r_nxt;
                        bout_q  <= brw_nxt;
                        // Sign test uses the captured operand MSBs only; bin plays no part.
                        ovf_q   <= (a_msb_q != b_msb_q) && (r_nxt[WIDTH-1] != a_msb_q);
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule
